// File: rtl/output_buffer_8x8.sv
// output_buffer_8x8: gathers an 8x8 matrix from lane-addressed writes, then drains it one row per transfer.
module output_buffer_8x8 #(
    parameter int DATA_BW   = 20,
    parameter int ADDR_SIZE = 6
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    input  logic [7:0]             in_lane_en,
    input  logic [8*DATA_BW-1:0]   in_data,
    input  logic [8*ADDR_SIZE-1:0] in_addr,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*DATA_BW-1:0]   out_data,
    output logic [2:0]             out_row,
    output logic                   out_last,
    output logic                   err_overflow,
    output logic                   err_dup
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]           state_q;
    logic [DEPTH-1:0]     mask_q, mask_d;
    logic [2:0]           row_q;
    logic                 err_ovf_q, err_dup_q, dup;
    logic [7:0]           lane_we;
    logic [DATA_BW-1:0]   mem_q [DEPTH];
    logic [ADDR_SIZE-1:0] lane_addr [8];
    logic [DATA_BW-1:0]   lane_data [8];

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign lane_addr[i] = in_addr[ADDR_SIZE*i +: ADDR_SIZE];
        assign lane_data[i] = in_data[DATA_BW*i +: DATA_BW];
        assign out_data[DATA_BW*i +: DATA_BW] = mem_q[{row_q, 3'(i)}];
    end

    assign lane_we = (in_valid && state_q == FILL) ? in_lane_en : 8'h00;

    // Walking lanes in order flags both re-writes of old entries and same-beat collisions.
    always_comb begin
        mask_d = mask_q;
        dup    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (lane_we[i]) begin
                dup = dup | mask_d[lane_addr[i]];
                mask_d[lane_addr[i]] = 1'b1;
            end
        end
    end

    // Later lanes override earlier ones, so the highest colliding lane wins.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (lane_we[i]) mem_q[lane_addr[i]] <= lane_data[i];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= FILL;
            mask_q    <= '0;
            row_q     <= 3'd0;
            err_dup_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            err_dup_q <= err_dup_q | dup;
            err_ovf_q <= err_ovf_q | (in_valid && |in_lane_en && state_q == DRAIN);
            if (state_q == FILL) begin
                mask_q <= mask_d;
                if (&mask_d) state_q <= DRAIN;
            end else if (out_ready) begin
                row_q <= row_q + 3'd1;
                if (row_q == 3'd7) begin
                    state_q <= FILL;
                    mask_q  <= '0;
                end
            end
        end
    end

    assign in_ready     = state_q == FILL;
    assign out_valid    = state_q == DRAIN;
    assign out_row      = row_q;
    assign out_last     = out_valid && row_q == 3'd7;
    assign err_overflow = err_ovf_q;
    assign err_dup      = err_dup_q;
endmodule

// File: doc/output_buffer_8x8.md
OUTPUT_BUFFER_8X8 -- requirements
Module: output_buffer_8x8

Interface
REQ-001 Parameter DATA_BW, default 20: width of one result element.
REQ-002 Parameter ADDR_SIZE, default 6: width of one lane address; addr[5:3] = row, addr[2:0] = col.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  write beat present on in_data/in_addr.
REQ-006 in_lane_en  input  8  per-lane write enable; lane i writes only if in_valid and in_lane_en[i].
REQ-007 in_data  input  8*DATA_BW  lane i element at [DATA_BW*i +: DATA_BW].
REQ-008 in_addr  input  8*ADDR_SIZE  lane i address at [ADDR_SIZE*i +: ADDR_SIZE], from the 6-bit address controller.
REQ-009 in_ready  output  1  high in FILL only.
REQ-010 out_valid  output  1  drain row available.
REQ-011 out_ready  input  1  downstream accepts the row.
REQ-012 out_data  output  8*DATA_BW  row elements, col c at [DATA_BW*c +: DATA_BW].
REQ-013 out_row  output  3  index of the row on out_data.
REQ-014 out_last  output  1  high with out_valid when out_row = 7.
REQ-015 err_overflow  output  1  sticky: in_valid with any lane enabled while not in FILL.
REQ-016 err_dup  output  1  sticky: write to an entry already written in the current fill.

Function
REQ-017 Storage: 64 entries x DATA_BW, index = in_addr lane value; plus 64-bit written mask.
REQ-018 States: FILL, DRAIN.
REQ-019 FILL: each enabled lane writes its element at its address; the corresponding mask bit sets.
REQ-020 Same address on two enabled lanes in one beat: the higher lane index wins; err_dup sets.
REQ-021 Write to an entry whose mask bit is already set: data overwritten; err_dup sets.
REQ-022 FILL -> DRAIN on the edge where the mask, including that beat's writes, becomes all ones; out_valid is high the following cycle (1-cycle latency from final write).
REQ-023 DRAIN: row counter starts at 0; out_data = entries {row,7}..{row,0}; out_valid = 1; out_row = counter.
REQ-024 Row transfers on out_valid && out_ready; counter increments; out_data/out_row hold while out_ready is low.
REQ-025 Transfer with out_last: DRAIN -> FILL; mask cleared, row counter cleared; in_ready is high the next cycle.
REQ-026 Beats with in_valid and in_lane_en all zero have no effect in any state.
REQ-027 In DRAIN, enabled in_valid beats are dropped: storage and mask are unchanged; err_overflow sets.
REQ-028 Storage contents are not cleared between matrices; only the mask is cleared.
REQ-029 err_dup and err_overflow clear only on reset.

Reset
REQ-030 rstn low asynchronously forces: state FILL, mask 0, row counter 0, out_valid 0, out_row 0, out_last 0, err flags 0, in_ready 1 once rstn is high.
REQ-031 Storage data is not reset; out_data is don't-care while out_valid is 0.
REQ-032 Reset mid-fill or mid-drain discards the partial matrix; the first post-reset beat starts a new fill.

Verification
REQ-033 Drive 8 beats from the 6-bit controller sequence (reset pattern then circular shifts), data = 100*row + col, all lanes enabled, out_ready = 1 -> rows 0..7 out on 8 consecutive cycles starting 1 cycle after beat 8; row r col c = 100r+c; out_last on row 7.
REQ-034 Same fill with out_ready toggling 1,0,0,1,...; check out_data/out_row stable while stalled; exactly 8 transfers occur; FILL is re-entered after row 7 is accepted.
REQ-035 Lane-skewed fill: lanes enabled one more per beat over 15 beats covering all 64 entries -> DRAIN only after the last entry; err_dup = 0.
REQ-036 Duplicate address on lanes 2 and 5 in one beat, values 7 and 9 -> entry holds 9; err_dup = 1.
REQ-037 in_valid with in_lane_en = 8'hFF during DRAIN -> drained data unchanged; err_overflow = 1; in_ready = 0.
REQ-038 rstn pulsed low after 4 fill beats -> out_valid = 0; mask cleared; a complete 8-beat fill then drains correctly.
